// File: rtl/write_back_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | write_back_pipe : MEM->WB pipeline register with write-back data select, |
// | load lane extraction (macro WB_LOAD_EXT_EN) and a retired-write counter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module write_back_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rt,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        dst_sel,
  input  logic              reg_write,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic              wb_en,
  output logic [31:0]       retired
);

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] sel_data;
  logic [REG_AW-1:0] sel_addr;

  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [REG_AW-1:0] wb_addr_d, wb_addr_q;
  logic              wb_en_d,   wb_en_q;
  logic [31:0]       retired_d, retired_q;

`ifdef WB_LOAD_EXT_EN
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Lanes always come from the low 32 bits, even for wider datapaths.
  always_comb begin
    half_lane = byte_off[1] ? mem_data[31:16] : mem_data[15:0];
    byte_lane = mem_data[{byte_off, 3'b000} +: 8];
    case (ld_size)
      2'b01:   load_data = {{(DATA_W-16){half_lane[15] & ~ld_unsigned}}, half_lane};
      2'b10:   load_data = {{(DATA_W-8){byte_lane[7] & ~ld_unsigned}}, byte_lane};
      default: load_data = mem_data;
    endcase
  end
`else
  logic unused_load_ctrl;

  assign unused_load_ctrl = ^{ld_size, ld_unsigned, byte_off};
  assign load_data        = mem_data;
`endif

  always_comb begin
    case (wb_sel)
      2'b01:   sel_data = load_data;
      2'b10:   sel_data = pc_plus4;
      default: sel_data = alu_res;
    endcase
    case (dst_sel)
      2'b01:   sel_addr = rt;
      2'b10:   sel_addr = '1;
      default: sel_addr = rd;
    endcase
  end

  always_comb begin
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = wb_en_q;
    retired_d = retired_q;
    if (flush) begin
      wb_data_d = '0;
      wb_addr_d = '0;
      wb_en_d   = 1'b0;
    end else if (!stall) begin
      wb_data_d = sel_data;
      wb_addr_d = sel_addr;
      wb_en_d   = valid_in & reg_write & (sel_addr != '0);
      if (wb_en_d) begin
        retired_d = retired_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      retired_q <= retired_d;
    end
  end

  assign wb_data = wb_data_q;
  assign wb_addr = wb_addr_q;
  assign wb_en   = wb_en_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: doc/write_back_pipe.md
WRITE_BACK_PIPE -- requirements
Module: write_back_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values are multiples of 8 that are at least 32.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  in  1  MEM-stage instruction valid.
REQ-006 SHALL have port stall  in  1  hold pipeline register.
REQ-007 SHALL have port flush  in  1  insert bubble.
REQ-008 SHALL have port alu_res  in  DATA_W  ALU result.
REQ-009 SHALL have port mem_data  in  DATA_W  memory read word.
REQ-010 SHALL have port pc_plus4  in  DATA_W  link value.
REQ-011 SHALL have port rd, rt  in  REG_AW each  destination candidates.
REQ-012 SHALL have port wb_sel  in  2  data source: 00 ALU, 01 mem, 10 pc_plus4, 11 ALU.
REQ-013 SHALL have port dst_sel  in  2  destination: 00 rd, 01 rt, 10 all-ones (link reg), 11 rd.
REQ-014 SHALL have port reg_write  in  1  instruction writes register file.
REQ-015 SHALL have port ld_size  in  2  00 word, 01 half, 10 byte, 11 word.
REQ-016 SHALL have port ld_unsigned  in  1  zero-extend sub-word loads.
REQ-017 SHALL have port byte_off  in  2  byte address offset within word.
REQ-018 SHALL have port wb_data  out  DATA_W  registered write data.
REQ-019 SHALL have port wb_addr  out  REG_AW  registered write address.
REQ-020 SHALL have port wb_en  out  1  registered write enable.
REQ-021 SHALL have port retired  out  32  count of committed register writes.

Function
REQ-022 SHALL compute data and address combinationally from inputs per wb_sel/dst_sel, then capture into output registers on the rising clk edge: latency exactly 1 cycle.
REQ-023 SHALL set next wb_en = valid_in & reg_write & (selected address != 0); writes to register 0 are suppressed, with data and address still captured.
REQ-024 SHALL, when stall=1 and flush=0, hold wb_data, wb_addr and wb_en unchanged and not increment retired.
REQ-025 SHALL, when flush=1 (priority over stall), load wb_en=0 with data and address don't-care-but-deterministic (zero).
REQ-026 SHALL, for half loads, take the 16-bit lane selected by byte_off[1]; byte_off[0] is ignored.
REQ-027 SHALL, for byte loads, take the 8-bit lane byte_off and extend it to DATA_W, sign-extending unless ld_unsigned=1.
REQ-028 SHALL apply load extraction only when wb_sel=01; other sources pass unmodified.
REQ-029 SHALL increment retired by 1 on each edge where the next wb_en=1 and the register is not stalled, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-030 SHALL, while rst=1, force wb_data=0, wb_addr=0, wb_en=0 and retired=0 immediately, regardless of clk.
REQ-031 SHALL discard any in-flight instruction on reset assertion; the first capture occurs on the first rising edge after rst deasserts.

Configuration
REQ-032 SHALL, with macro WB_LOAD_EXT_EN defined, implement REQ-026/REQ-027.
REQ-033 SHALL, without WB_LOAD_EXT_EN, pass mem_data through as a full word and ignore ld_size, ld_unsigned and byte_off.

Verification
REQ-034 Bench SHALL cover ALU path: wb_sel=00, alu_res=0x0000_1234, dst_sel=00, rd=7, reg_write=1, valid=1 -> next cycle wb_data=0x1234, wb_addr=7, wb_en=1, retired=1.
REQ-035 Bench SHALL cover signed byte load (EN defined): mem_data=0x1280_FF34, byte_off=2, ld_size=10, ld_unsigned=0 -> wb_data=0xFFFF_FF80; with ld_unsigned=1 -> 0x0000_0080.
REQ-036 Bench SHALL cover link write: wb_sel=10, dst_sel=10, pc_plus4=0x0040_0008 -> wb_addr=31, wb_data=0x0040_0008, wb_en=1.
REQ-037 Bench SHALL cover register-0 suppression and flush: rt=0, dst_sel=01 -> wb_en=0 and retired unchanged; flush=1 with stall=1 -> wb_en=0.
REQ-038 Bench SHALL cover stall hold: stall=1 for 3 cycles with changing inputs -> outputs and retired constant.
REQ-039 Bench SHALL cover counter wrap and async reset: preset retired=0xFFFF_FFFF, commit one write -> retired=0; assert rst mid-cycle -> all outputs 0 before the next edge.
